// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects,
// stall FSM states and the forwarding-select helper.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN  = 1'b0,
        MISS = 1'b1
    } state_t;

    // MEM wins over WB because it holds the younger result; x0 never forwards.
    function automatic logic [1:0] fwd_select(
        input logic       we_mem,
        input logic [4:0] dest_mem,
        input logic       we_wb,
        input logic [4:0] dest_wb,
        input logic [4:0] src
    );
        if (we_mem && (dest_mem != 5'd0) && (dest_mem == src))
            return FWD_MEM;
        else if (we_wb && (dest_wb != 5'd0) && (dest_wb == src))
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating event counter: counts up on inc, sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst)
            cnt <= '0;
        else if (inc && (cnt != {W{1'b1}}))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: bubble/flush generation, EX forwarding selects,
// data-cache stall FSM and saturating performance counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       reg1_src_ID,
    input  logic [4:0]       reg2_src_ID,
    input  logic [4:0]       reg1_src_EX,
    input  logic [4:0]       reg2_src_EX,
    input  logic [4:0]       reg_dest_EX,
    input  logic [4:0]       reg_dest_MEM,
    input  logic [4:0]       reg_dest_WB,
    input  logic             reg_write_en_MEM,
    input  logic             reg_write_en_WB,
    input  logic             load_EX,
    input  logic             br_taken_EX,
    input  logic             jalr_EX,
    input  logic             jal_ID,
    input  logic             dcache_miss,
    output logic             bubbleF,
    output logic             bubbleD,
    output logic             bubbleE,
    output logic             bubbleM,
    output logic             bubbleW,
    output logic             flushF,
    output logic             flushD,
    output logic             flushE,
    output logic             flushM,
    output logic             flushW,
    output logic [1:0]       op1_sel,
    output logic [1:0]       op2_sel,
    output logic [CNT_W-1:0] load_use_cnt,
    output logic [CNT_W-1:0] miss_evt_cnt,
    output logic [CNT_W-1:0] miss_cyc_cnt,
    output logic [CNT_W-1:0] redirect_cnt,
    output logic             state_dbg
);

    state_t state, state_nxt;
    logic   load_use_hit;
    logic   redirect_act;
    logic   load_use_act;
    logic   miss_start;

    assign load_use_hit = load_EX && (reg_dest_EX != 5'd0) &&
                          ((reg_dest_EX == reg1_src_ID) || (reg_dest_EX == reg2_src_ID));

    // Exclusive priority chain: reset, miss, redirect, jal, load-use.
    assign redirect_act = !rst && !dcache_miss && (br_taken_EX || jalr_EX);
    assign load_use_act = !rst && !dcache_miss && !br_taken_EX && !jalr_EX &&
                          !jal_ID && load_use_hit;
    assign miss_start   = !rst && (state == RUN) && dcache_miss;
    assign state_dbg    = state;

    always_ff @(posedge clk) begin
        if (rst)
            state <= RUN;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (dcache_miss)  state_nxt = MISS;
            MISS:    if (!dcache_miss) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_comb begin
        bubbleF = 1'b0;
        bubbleD = 1'b0;
        bubbleE = 1'b0;
        bubbleM = 1'b0;
        bubbleW = 1'b0;
        flushF  = 1'b0;
        flushD  = 1'b0;
        flushE  = 1'b0;
        flushM  = 1'b0;
        flushW  = 1'b0;
        op1_sel = FWD_REG;
        op2_sel = FWD_REG;
        if (rst) begin
            flushF = 1'b1;
            flushD = 1'b1;
            flushE = 1'b1;
            flushM = 1'b1;
            flushW = 1'b1;
        end else begin
            op1_sel = fwd_select(reg_write_en_MEM, reg_dest_MEM,
                                 reg_write_en_WB, reg_dest_WB, reg1_src_EX);
            op2_sel = fwd_select(reg_write_en_MEM, reg_dest_MEM,
                                 reg_write_en_WB, reg_dest_WB, reg2_src_EX);
            if (dcache_miss) begin
                bubbleF = 1'b1;
                bubbleD = 1'b1;
                bubbleE = 1'b1;
                bubbleM = 1'b1;
                bubbleW = 1'b1;
            end else if (br_taken_EX || jalr_EX) begin
                flushD = 1'b1;
                flushE = 1'b1;
            end else if (jal_ID) begin
                flushD = 1'b1;
            end else if (load_use_hit) begin
                bubbleF = 1'b1;
                bubbleD = 1'b1;
                flushE  = 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_load_use_cnt (
        .clk(clk), .rst(rst), .inc(load_use_act), .cnt(load_use_cnt)
    );

    sat_counter #(.W(CNT_W)) u_miss_evt_cnt (
        .clk(clk), .rst(rst), .inc(miss_start), .cnt(miss_evt_cnt)
    );

    sat_counter #(.W(CNT_W)) u_miss_cyc_cnt (
        .clk(clk), .rst(rst), .inc(dcache_miss), .cnt(miss_cyc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_redirect_cnt (
        .clk(clk), .rst(rst), .inc(redirect_act), .cnt(redirect_cnt)
    );

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the RV32I core.
- Drives bubbleX/flushX for every segment register (IF/ID, ID/EX, EX/MEM, MEM/WB, PC) and the EX-stage operand forwarding selects.
- Consumes the register addresses latched by the ID/EX address segment register and the destination addresses of later stages.
- Holds a small stall FSM and saturating performance counters.

Parameters:
- CNT_W, 32, width of each performance counter.

Ports:
- clk  in  1  core clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-high reset.
- reg1_src_ID, reg2_src_ID  in  5  ID-stage source register addresses.
- reg1_src_EX, reg2_src_EX  in  5  EX-stage source register addresses.
- reg_dest_EX, reg_dest_MEM, reg_dest_WB  in  5  destination addresses per stage.
- reg_write_en_MEM, reg_write_en_WB  in  1  register write enables.
- load_EX  in  1  EX instruction is a load.
- br_taken_EX, jalr_EX  in  1  redirect resolved in EX.
- jal_ID  in  1  jal decoded in ID.
- dcache_miss  in  1  level signal; high while the data cache stalls.
- bubbleF, bubbleD, bubbleE, bubbleM, bubbleW  out  1  hold the segment register.
- flushF, flushD, flushE, flushM, flushW  out  1  zero the segment register.
- op1_sel, op2_sel  out  2  EX operand forwarding select.
- load_use_cnt, miss_evt_cnt, miss_cyc_cnt, redirect_cnt  out  CNT_W  performance counters.

Behaviour:
- Reset:
  - Registered: state=RUN; all counters=0.
  - While rst=1: all five flush outputs=1; all bubbles=0; op1_sel=op2_sel=FWD_REG.
- Forwarding (combinational, for each operand k):
  - FWD_MEM if reg_write_en_MEM, reg_dest_MEM!=0 and reg_dest_MEM==regk_src_EX.
  - Else FWD_WB if the same conditions hold on WB.
  - Else FWD_REG.
  - MEM has priority over WB. x0 is never forwarded.
- Hazard priority (combinational, highest first; all unlisted outputs=0):
  1. rst: flush all.
  2. dcache_miss=1: bubble all five stages. Suppresses every flush and the load-use stall, because a bubble overrides a flush in the segment registers.
  3. br_taken_EX or jalr_EX: flushD=1, flushE=1.
  4. jal_ID: flushD=1.
  5. Load-use (load_EX, reg_dest_EX!=0, reg_dest_EX equals reg1_src_ID or reg2_src_ID): bubbleF=1, bubbleD=1, flushE=1. Exactly one cycle; the load has then moved to MEM and forwarding resolves it.
  - Redirect and load-use in the same cycle: the redirect wins and no stall is taken.
- FSM (registered):
  - States: RUN, MISS.
  - RUN -> MISS when dcache_miss=1.
  - MISS -> RUN when dcache_miss=0.
  - The redirect or load-use condition held during MISS is re-evaluated on the first RUN cycle, because the pipeline is frozen. No pending-flag storage is required.
- Counters (saturate at all-ones; no wrap):
  - miss_evt_cnt: +1 on each RUN->MISS transition.
  - miss_cyc_cnt: +1 every cycle dcache_miss=1.
  - load_use_cnt: +1 every cycle the load-use stall is actually applied (priority 5 active).
  - redirect_cnt: +1 every cycle priority 3 is active.
- rst asserted mid-MISS: next state is RUN and counters clear, regardless of dcache_miss.

Decomposition:
- Shared package: FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; state encoding RUN=1'b0, MISS=1'b1.
- One sub-module, sat_counter (parameter W; inputs clk, rst, inc; output cnt), instantiated four times.

Test Plan:
- Forwarding:
  - reg1_src_EX=5, reg_dest_MEM=5 and reg_dest_WB=5, both write enables=1 -> op1_sel=FWD_MEM.
  - Same with reg_write_en_MEM=0 -> FWD_WB.
  - reg_dest_MEM=0 matching reg1_src_EX=0 -> FWD_REG.
- Load-use:
  - load_EX=1, reg_dest_EX=7, reg2_src_ID=7 for one cycle -> bubbleF=bubbleD=flushE=1 that cycle only; load_use_cnt 0->1.
  - reg_dest_EX=0 -> no stall.
- Redirect vs load-use: br_taken_EX=1 together with a load-use match -> flushD=flushE=1, bubbleF=0; redirect_cnt=1, load_use_cnt=0.
- Miss:
  - dcache_miss high 4 cycles while br_taken_EX=1 -> all bubbles=1 and all flushes=0 for those 4 cycles.
  - Next cycle: flushD=flushE=1; miss_evt_cnt=1, miss_cyc_cnt=4.
- Reset mid-miss: rst=1 in cycle 2 of a miss with dcache_miss still 1 -> that cycle all flushes=1 and all bubbles=0; next cycle state=RUN and counters=0.
- Saturation: preload via CNT_W=4, hold dcache_miss 20 cycles -> miss_cyc_cnt stops at 15.
